wb_stage_nway: RTL and testbench

- Parametrised writeback stage for the N-issue pipeline.
- Registers the MEM→WB bus with stall/flush bubbling and drives the register-file/HI-LO write bus.
- Resolves same-destination conflicts between lanes, younger lane winning.
- Serialises retired lanes through a trace FIFO onto a single-commit-per-cycle debug port, using the clock only, with no delays or dual-edge logic.
- Sits between MEM and the regfile/hilo unit; raises a stall request when the trace FIFO cannot absorb a full issue group.

---
 rtl/wb_stage_nway.sv | 153 +++++++++++++++
 tb/tb_wb_stage_nway.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage_nway.sv
// Writeback stage for the N-issue pipeline: MEM->WB register, regfile/HI-LO write bus
// with younger-lane-wins conflict resolution, and a trace FIFO feeding a one-commit debug port.
`timescale 1ns/1ps
module wb_stage_nway #(
    parameter int LANES     = 2,
    parameter int HILO_WD   = 66,
    parameter int STALL_WD  = 6,
    parameter int STALL_BIT = 5,
    parameter int DBG_DEPTH = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic [STALL_WD-1:0]              stall,
    input  logic [LANES*(HILO_WD+71)-1:0]    mem_to_wb_bus,
    output logic [LANES*(HILO_WD+38)-1:0]    wb_to_rf_bus,
    output logic                             wb_stall_req,
    output logic [31:0]                      debug_wb_pc,
    output logic [3:0]                       debug_wb_rf_wen,
    output logic [4:0]                       debug_wb_rf_wnum,
    output logic [31:0]                      debug_wb_rf_wdata,
    output logic                             debug_trace_empty
);

    localparam int IN_W  = HILO_WD + 71;
    localparam int OUT_W = HILO_WD + 38;
    localparam int ENT_W = 70;
    localparam int AW    = $clog2(DBG_DEPTH);
    localparam int CW    = AW + 1;
    localparam logic [CW:0] STALL_TH = (CW+1)'(DBG_DEPTH - LANES);

    logic [LANES*IN_W-1:0] wb_reg;

    logic [LANES-1:0]      lane_valid;
    logic [LANES-1:0]      lane_we;
    logic [LANES-1:0]      lane_kill;
    logic [LANES-1:0]      lane_nz;
    logic [LANES-1:0]      lane_we_out;
    logic [4:0]            lane_waddr [LANES];
    logic [31:0]           lane_wdata [LANES];
    logic [31:0]           lane_pc    [LANES];
    logic [HILO_WD-1:0]    lane_hilo  [LANES];
    logic [ENT_W-1:0]      lane_entry [LANES];
    logic [AW-1:0]         push_ofs   [LANES];
    logic [AW-1:0]         wr_idx     [LANES];

    logic [ENT_W-1:0]      fifo_mem [DBG_DEPTH];
    logic [AW-1:0]         head_ptr;
    logic [AW-1:0]         tail_ptr;
    logic [CW-1:0]         count;
    logic [CW-1:0]         push_cnt;
    logic                  do_pop;
    logic [ENT_W-1:0]      head_entry;
    logic [CW:0]           occ_next;

    logic                  unused_stall;
    assign unused_stall = ^stall;

    // Any of rst/flush/stall turns the register into a bubble rather than holding it.
    always_ff @(posedge clk) begin
        if (rst || flush || stall[STALL_BIT]) begin
            wb_reg <= '0;
        end else begin
            wb_reg <= mem_to_wb_bus;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign lane_valid[g] = wb_reg[g*IN_W + HILO_WD + 70];
        assign lane_hilo[g]  = wb_reg[g*IN_W + 70 +: HILO_WD];
        assign lane_pc[g]    = wb_reg[g*IN_W + 38 +: 32];
        assign lane_we[g]    = wb_reg[g*IN_W + 37];
        assign lane_waddr[g] = wb_reg[g*IN_W + 32 +: 5];
        assign lane_wdata[g] = wb_reg[g*IN_W +: 32];
        assign lane_nz[g]    = |lane_waddr[g];
        assign lane_entry[g] = {lane_pc[g], lane_we[g], lane_waddr[g], lane_wdata[g]};
        assign wr_idx[g]     = tail_ptr + push_ofs[g];
        assign wb_to_rf_bus[g*OUT_W +: OUT_W] =
            {lane_hilo[g], lane_we_out[g], lane_waddr[g], lane_wdata[g]};
    end

    // A younger lane writing the same register suppresses every older lane's write.
    always_comb begin
        lane_kill = '0;
        for (int j = 0; j < LANES; j++) begin
            for (int i = j + 1; i < LANES; i++) begin
                if (lane_valid[i] && lane_we[i] && (lane_waddr[i] == lane_waddr[j])) begin
                    lane_kill[j] = 1'b1;
                end
            end
        end
    end

    assign lane_we_out = lane_valid & lane_we & lane_nz & ~lane_kill;

    // Valid lanes pack densely into the FIFO in lane order.
    always_comb begin
        logic [CW-1:0] run;
        run = '0;
        for (int j = 0; j < LANES; j++) begin
            push_ofs[j] = run[AW-1:0];
            run         = run + CW'(lane_valid[j]);
        end
        push_cnt = run;
    end

    assign do_pop     = (count != '0);
    assign head_entry = fifo_mem[head_ptr];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int j = 0; j < LANES; j++) begin
                if (lane_valid[j]) begin
                    fifo_mem[wr_idx[j]] <= lane_entry[j];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            head_ptr <= head_ptr + AW'(do_pop);
            tail_ptr <= tail_ptr + push_cnt[AW-1:0];
            count    <= count + push_cnt - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            debug_wb_pc       <= '0;
            debug_wb_rf_wen   <= '0;
            debug_wb_rf_wnum  <= '0;
            debug_wb_rf_wdata <= '0;
        end else if (do_pop) begin
            debug_wb_pc       <= head_entry[69:38];
            debug_wb_rf_wen   <= {4{head_entry[37]}};
            debug_wb_rf_wnum  <= head_entry[36:32];
            debug_wb_rf_wdata <= head_entry[31:0];
        end else begin
            debug_wb_rf_wen   <= '0;
        end
    end

    // Occupancy after the next edge; above the threshold a further full group could overflow.
    assign occ_next          = {1'b0, count} + {1'b0, push_cnt} - (CW+1)'(do_pop);
    assign wb_stall_req      = (occ_next > STALL_TH);
    assign debug_trace_empty = (count == '0) && (push_cnt == '0);

endmodule

// File: tb/tb_wb_stage_nway.sv
// Self-checking bench for wb_stage_nway: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based reference model.
`timescale 1ns/1ps
module tb_wb_stage_nway;
    localparam int LANES = 2;
    localparam int H     = 66;
    localparam int SW    = 6;
    localparam int SB    = 5;
    localparam int D     = 8;
    localparam int LW    = H + 71;
    localparam int OW    = H + 38;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  flush;
    logic [SW-1:0]         stall;
    logic [LANES*LW-1:0]   mem_to_wb_bus;
    logic [LANES*OW-1:0]   wb_to_rf_bus;
    logic                  wb_stall_req;
    logic [31:0]           debug_wb_pc;
    logic [3:0]            debug_wb_rf_wen;
    logic [4:0]            debug_wb_rf_wnum;
    logic [31:0]           debug_wb_rf_wdata;
    logic                  debug_trace_empty;

    wb_stage_nway #(.LANES(LANES), .HILO_WD(H), .STALL_WD(SW), .STALL_BIT(SB), .DBG_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall),
        .mem_to_wb_bus(mem_to_wb_bus), .wb_to_rf_bus(wb_to_rf_bus),
        .wb_stall_req(wb_stall_req), .debug_wb_pc(debug_wb_pc),
        .debug_wb_rf_wen(debug_wb_rf_wen), .debug_wb_rf_wnum(debug_wb_rf_wnum),
        .debug_wb_rf_wdata(debug_wb_rf_wdata), .debug_trace_empty(debug_trace_empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         v;
        logic [H-1:0] hilo;
        logic [31:0]  pc;
        logic         we;
        logic [4:0]   wa;
        logic [31:0]  wd;
    } lane_t;

    typedef struct {
        logic [31:0] pc;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
    } ent_t;

    lane_t       in_l [LANES];
    lane_t       mreg [LANES];
    ent_t        q[$];
    logic [31:0] e_pc;
    logic [3:0]  e_wen;
    logic [4:0]  e_wnum;
    logic [31:0] e_wdata;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic lane_t mk(input logic v, input logic [31:0] pc, input logic we,
                                 input logic [4:0] wa, input logic [31:0] wd);
        lane_t l;
        l.v    = v;
        l.hilo = H'({$urandom(), $urandom(), $urandom()});
        l.pc   = pc;
        l.we   = we;
        l.wa   = wa;
        l.wd   = wd;
        return l;
    endfunction

    function automatic lane_t bubble();
        lane_t l;
        l.v = 1'b0; l.hilo = '0; l.pc = '0; l.we = 1'b0; l.wa = '0; l.wd = '0;
        return l;
    endfunction

    task automatic idle();
        for (int j = 0; j < LANES; j++) in_l[j] = bubble();
    endtask

    task automatic drive();
        for (int j = 0; j < LANES; j++)
            mem_to_wb_bus[j*LW +: LW] = {in_l[j].v, in_l[j].hilo, in_l[j].pc,
                                         in_l[j].we, in_l[j].wa, in_l[j].wd};
    endtask

    function automatic logic [LANES*OW-1:0] exp_rf();
        logic [LANES*OW-1:0] r;
        logic                kill;
        logic                weo;
        r = '0;
        for (int j = 0; j < LANES; j++) begin
            kill = 1'b0;
            for (int i = j + 1; i < LANES; i++)
                if (mreg[i].v && mreg[i].we && mreg[i].wa == mreg[j].wa) kill = 1'b1;
            weo = mreg[j].v && mreg[j].we && (mreg[j].wa != 5'd0) && !kill;
            r[j*OW +: OW] = {mreg[j].hilo, weo, mreg[j].wa, mreg[j].wd};
        end
        return r;
    endfunction

    function automatic int nvalid();
        int n = 0;
        for (int j = 0; j < LANES; j++) if (mreg[j].v) n++;
        return n;
    endfunction

    function automatic logic [LANES-1:0] rf_we();
        logic [LANES-1:0] w;
        for (int j = 0; j < LANES; j++) w[j] = wb_to_rf_bus[j*OW + 37];
        return w;
    endfunction

    // Advance one clock: update the model from the current inputs, then compare all outputs.
    task automatic step();
        int  c;
        int  nv;
        logic exp_req;
        drive();
        if (rst) begin
            q.delete();
            e_pc = '0; e_wen = '0; e_wnum = '0; e_wdata = '0;
            for (int j = 0; j < LANES; j++) mreg[j] = bubble();
        end else begin
            if (q.size() > 0) begin
                ent_t e;
                e = q.pop_front();
                e_pc = e.pc; e_wen = {4{e.we}}; e_wnum = e.wa; e_wdata = e.wd;
            end else begin
                e_wen = '0;
            end
            for (int j = 0; j < LANES; j++) begin
                if (mreg[j].v) begin
                    ent_t n;
                    n.pc = mreg[j].pc; n.we = mreg[j].we; n.wa = mreg[j].wa; n.wd = mreg[j].wd;
                    q.push_back(n);
                end
            end
            chk("fifo_no_overflow", q.size() <= D, 1);
            for (int j = 0; j < LANES; j++)
                mreg[j] = (flush || stall[SB]) ? bubble() : in_l[j];
        end
        @(posedge clk);
        #1;
        c  = q.size();
        nv = nvalid();
        exp_req = (c + nv - ((c != 0) ? 1 : 0)) > (D - LANES);
        chk("wb_to_rf_bus", wb_to_rf_bus, exp_rf());
        chk("wb_stall_req", wb_stall_req, exp_req);
        chk("debug_wb_pc", debug_wb_pc, e_pc);
        chk("debug_wb_rf_wen", debug_wb_rf_wen, e_wen);
        chk("debug_wb_rf_wnum", debug_wb_rf_wnum, e_wnum);
        chk("debug_wb_rf_wdata", debug_wb_rf_wdata, e_wdata);
        chk("debug_trace_empty", debug_trace_empty, (c == 0) && (nv == 0));
    endtask

    initial begin
        logic [31:0] log_q[$];
        int          g;
        int          guard;
        logic        seen;

        rst = 1'b1; flush = 1'b0; stall = '0;
        idle();
        for (int j = 0; j < LANES; j++) mreg[j] = bubble();
        e_pc = '0; e_wen = '0; e_wnum = '0; e_wdata = '0;
        step(); step();
        chk("reset_empty", debug_trace_empty, 1);
        chk("reset_wen", debug_wb_rf_wen, 0);
        rst = 1'b0;
        step();

        // dual issue, independent destinations
        in_l[0] = mk(1, 32'hBFC00000, 1, 5'd2, 32'h11);
        in_l[1] = mk(1, 32'hBFC00004, 1, 5'd3, 32'h22);
        step();
        chk("dual_we", rf_we(), 2'b11);
        idle();
        step(); step();
        chk("dual_pc0", debug_wb_pc, 32'hBFC00000);
        chk("dual_wen0", debug_wb_rf_wen, 4'hF);
        chk("dual_wnum0", debug_wb_rf_wnum, 5'd2);
        chk("dual_wdata0", debug_wb_rf_wdata, 32'h11);
        step();
        chk("dual_pc1", debug_wb_pc, 32'hBFC00004);
        chk("dual_wnum1", debug_wb_rf_wnum, 5'd3);
        chk("dual_wdata1", debug_wb_rf_wdata, 32'h22);
        step();
        chk("dual_drained_wen", debug_wb_rf_wen, 4'h0);

        // same destination: younger lane wins, trace keeps both
        in_l[0] = mk(1, 32'h00000100, 1, 5'd5, 32'd1);
        in_l[1] = mk(1, 32'h00000104, 1, 5'd5, 32'd2);
        step();
        chk("same_we", rf_we(), 2'b10);
        chk("same_wdata1", wb_to_rf_bus[OW +: 32], 32'd2);
        idle();
        step(); step();
        chk("same_pc0", debug_wb_pc, 32'h00000100);
        chk("same_wen0", debug_wb_rf_wen, 4'hF);
        chk("same_wdata0", debug_wb_rf_wdata, 32'd1);
        step();
        chk("same_pc1", debug_wb_pc, 32'h00000104);
        chk("same_wdata1_dbg", debug_wb_rf_wdata, 32'd2);

        // stall bubble
        in_l[0] = mk(1, 32'h200, 1, 5'd7, 32'h77);
        in_l[1] = mk(1, 32'h204, 1, 5'd8, 32'h88);
        stall[SB] = 1'b1;
        step();
        chk("stall_we", rf_we(), 2'b00);
        stall = '0;
        idle();
        repeat (3) step();
        chk("stall_drain_wen", debug_wb_rf_wen, 4'h0);
        chk("stall_empty", debug_trace_empty, 1);

        // back-to-back full groups with upstream honouring wb_stall_req
        g = 0; guard = 0; seen = 1'b0;
        while (g < 10 && guard < 200) begin
            in_l[0] = mk(1, 32'h80000000 + 32'(g*8),     1, 5'd1, 32'(g));
            in_l[1] = mk(1, 32'h80000000 + 32'(g*8 + 4), 1, 5'd2, 32'(g + 100));
            stall[SB] = wb_stall_req;
            if (wb_stall_req) seen = 1'b1;
            step();
            if (!stall[SB]) g++;
            guard++;
            if (debug_wb_rf_wen == 4'hF) log_q.push_back(debug_wb_pc);
        end
        stall = '0;
        idle();
        guard = 0;
        while (log_q.size() < 20 && guard < 40) begin
            step();
            if (debug_wb_rf_wen == 4'hF) log_q.push_back(debug_wb_pc);
            guard++;
        end
        step();
        if (debug_wb_rf_wen == 4'hF) log_q.push_back(debug_wb_pc);
        chk("burst_stall_seen", seen, 1);
        chk("burst_count", log_q.size(), 20);
        for (int i = 0; i < 20; i++)
            if (i < log_q.size()) chk("burst_pc", log_q[i], 32'h80000000 + 32'(i*4));

        // flush with 3 entries queued
        in_l[0] = mk(1, 32'h300, 1, 5'd1, 32'h1);
        in_l[1] = mk(1, 32'h304, 1, 5'd2, 32'h2);
        step();
        in_l[0] = mk(1, 32'h308, 1, 5'd3, 32'h3);
        in_l[1] = mk(1, 32'h30C, 1, 5'd4, 32'h4);
        step();
        idle();
        step();
        in_l[0] = mk(1, 32'h400, 1, 5'd9, 32'h9);
        in_l[1] = mk(1, 32'h404, 1, 5'd10, 32'hA);
        flush = 1'b1;
        step();
        flush = 1'b0;
        idle();
        chk("flush_we", rf_we(), 2'b00);
        chk("flush_not_empty", debug_trace_empty, 0);
        step(); step();
        chk("flush_drained_empty", debug_trace_empty, 1);
        step();
        chk("flush_no_extra", debug_wb_rf_wen, 4'h0);

        // reset while 4 entries are queued
        for (int k = 0; k < 3; k++) begin
            in_l[0] = mk(1, 32'h500 + 32'(k*8),     1, 5'd1, 32'(k));
            in_l[1] = mk(1, 32'h500 + 32'(k*8 + 4), 1, 5'd2, 32'(k));
            step();
        end
        idle();
        step();
        in_l[0] = mk(1, 32'h600, 1, 5'd3, 32'h6);
        in_l[1] = mk(1, 32'h604, 1, 5'd4, 32'h7);
        rst = 1'b1;
        step();
        chk("rst_pc", debug_wb_pc, 0);
        chk("rst_wen", debug_wb_rf_wen, 0);
        chk("rst_wnum", debug_wb_rf_wnum, 0);
        chk("rst_wdata", debug_wb_rf_wdata, 0);
        chk("rst_empty", debug_trace_empty, 1);
        chk("rst_stall_req", wb_stall_req, 0);
        chk("rst_rf_bus", wb_to_rf_bus, 0);
        rst = 1'b0;
        idle();
        repeat (5) begin
            step();
            chk("rst_no_stale", debug_wb_rf_wen, 4'h0);
        end

        // randomized traffic
        repeat (300) begin
            for (int j = 0; j < LANES; j++)
                in_l[j] = mk(1'($urandom_range(0, 1)), $urandom(), 1'($urandom_range(0, 1)),
                             5'($urandom_range(0, 7)), $urandom());
            flush = ($urandom_range(0, 19) == 0);
            rst   = ($urandom_range(0, 99) == 0);
            stall = SW'($urandom()) & ~(SW'(1) << SB);
            stall[SB] = wb_stall_req | ($urandom_range(0, 7) == 0);
            step();
        end
        rst = 1'b0; flush = 1'b0; stall = '0;
        idle();
        repeat (12) step();
        chk("final_empty", debug_trace_empty, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
